// File: rtl/counter_updown_mod_pkg.sv
// rtl/counter_updown_mod_pkg.sv - shared constants and load clamp helper for the up/down counter
package counter_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Widest counter supported; the clamp helper works at this width
   localparam int MAX_WIDTH = 31;

   // Limit a requested load value to the top of the counting range
   function automatic logic [MAX_WIDTH-1:0] clamp_load(input logic [MAX_WIDTH-1:0] val,
                                                       input logic [MAX_WIDTH-1:0] max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// rtl/counter_updown_mod_if.sv - control and status bundle of the up/down counter
interface counter_updown_mod_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up_dn;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             ovf;

   modport master (
      output en, up_dn, clr, load, load_val,
      input  count, tc, wrap, ovf
   );

   modport slave (
      input  en, up_dn, clr, load, load_val,
      output count, tc, wrap, ovf
   );
endinterface

// File: rtl/counter_updown_mod_step.sv
// rtl/counter_updown_mod_step.sv - combinational next-count computation for one step
module counter_step
   import counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 255
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up_dn,
   input  mode_e            mode,
   output logic [WIDTH-1:0] next_count,
   output logic             at_bound,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

   // Compare against the range end first, so the step never leaves 0..MAX_VAL
   always_comb begin
      next_count = count;
      at_bound   = 1'b0;
      wrapped    = 1'b0;
      if (up_dn == DIR_UP) begin
         if (count == MAX_C) begin
            at_bound = 1'b1;
            if (mode == MODE_WRAP) begin
               next_count = '0;
               wrapped    = 1'b1;
            end
         end else begin
            next_count = count + WIDTH'(1);
         end
      end else begin
         if (count == '0) begin
            at_bound = 1'b1;
            if (mode == MODE_WRAP) begin
               next_count = MAX_C;
               wrapped    = 1'b1;
            end
         end else begin
            next_count = count - WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - modulo-N up/down counter with load, clear, wrap/saturate and status
module counter_updown_mod
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_VAL  = (1 << WIDTH) - 1,
   parameter bit SATURATE = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   counter_updown_mod_if.slave  bus
);

   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("counter_updown_mod: WIDTH must be in 1..%0d", MAX_WIDTH);
   end
   if (MAX_VAL < 1 || longint'(MAX_VAL) >= (longint'(1) << WIDTH)) begin : g_bad_max
      $error("counter_updown_mod: MAX_VAL must be >= 1 and < 2**WIDTH");
   end

   localparam mode_e            MODE  = SATURATE ? MODE_SAT : MODE_WRAP;
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] count_q;
   logic             wrap_q;
   logic             ovf_q;
   logic [WIDTH-1:0] next_count;
   logic             at_bound;
   logic             wrapped;
   logic [WIDTH-1:0] load_clamped;

   counter_step #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL)
   ) u_step (
      .count      (count_q),
      .up_dn      (bus.up_dn),
      .mode       (MODE),
      .next_count (next_count),
      .at_bound   (at_bound),
      .wrapped    (wrapped)
   );

   assign load_clamped = WIDTH'(clamp_load(MAX_WIDTH'(bus.load_val), MAX_WIDTH'(MAX_VAL)));

   // Priority mux into the count, wrap and sticky overflow registers: clr > load > en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.clr) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.load) begin
         count_q <= load_clamped;
         wrap_q  <= 1'b0;
      end else if (bus.en) begin
         count_q <= next_count;
         wrap_q  <= wrapped;
         ovf_q   <= ovf_q | at_bound;
      end else begin
         wrap_q  <= 1'b0;
      end
   end

   assign bus.count = count_q;
   assign bus.wrap  = wrap_q;
   assign bus.ovf   = ovf_q;
   assign bus.tc    = ((bus.up_dn == DIR_UP) && (count_q == MAX_C)) ||
                      ((bus.up_dn == DIR_DN) && (count_q == '0));

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - scoreboard bench for wrap, saturate and 2-bit counter variants
module tb_counter_updown_mod;

   typedef struct {
      int cnt;
      int w;
      int o;
      int t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;

   int checks = 0;
   int failures = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int m_cnt[3] = '{0, 0, 0};
   int m_w[3]   = '{0, 0, 0};
   int m_o[3]   = '{0, 0, 0};
   int m_max[3] = '{9, 9, 3};
   int m_sat[3] = '{0, 1, 0};
   int m_mod[3] = '{16, 16, 4};

   always #5 clk = ~clk;

   counter_updown_mod_if #(.WIDTH(4)) if_a ();
   counter_updown_mod_if #(.WIDTH(4)) if_b ();
   counter_updown_mod_if #(.WIDTH(2)) if_c ();

   assign if_a.en = en;
   assign if_a.up_dn = up_dn;
   assign if_a.clr = clr;
   assign if_a.load = load;
   assign if_a.load_val = load_val;
   assign if_b.en = en;
   assign if_b.up_dn = up_dn;
   assign if_b.clr = clr;
   assign if_b.load = load;
   assign if_b.load_val = load_val;
   assign if_c.en = en;
   assign if_c.up_dn = up_dn;
   assign if_c.clr = clr;
   assign if_c.load = load;
   assign if_c.load_val = load_val[1:0];

   counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_a (
      .clk (clk), .rst (rst), .bus (if_a.slave));
   counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_b (
      .clk (clk), .rst (rst), .bus (if_b.slave));
   counter_updown_mod #(.WIDTH(2), .MAX_VAL(3), .SATURATE(1'b0)) dut_c (
      .clk (clk), .rst (rst), .bus (if_c.slave));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: counting range 0..max, wrap is modular arithmetic, saturate clips
   function automatic exp_t model_step(int k, bit e, bit u, bit c, bit l, int lv);
      exp_t r;
      int   nxt;
      int   lvk;
      m_w[k] = 0;
      if (c) begin
         m_cnt[k] = 0;
         m_o[k]   = 0;
      end else if (l) begin
         lvk      = lv % m_mod[k];
         m_cnt[k] = (lvk > m_max[k]) ? m_max[k] : lvk;
      end else if (e) begin
         nxt = u ? m_cnt[k] + 1 : m_cnt[k] - 1;
         if (nxt > m_max[k] || nxt < 0) begin
            m_o[k] = 1;
            if (m_sat[k] != 0) begin
               nxt = (nxt < 0) ? 0 : m_max[k];
            end else begin
               m_w[k] = 1;
               nxt = (nxt + m_max[k] + 1) % (m_max[k] + 1);
            end
         end
         m_cnt[k] = nxt;
      end
      r.cnt = m_cnt[k];
      r.w   = m_w[k];
      r.o   = m_o[k];
      r.t   = u ? int'(m_cnt[k] == m_max[k]) : int'(m_cnt[k] == 0);
      return r;
   endfunction

   task automatic apply(input bit e, input bit u, input bit c, input bit l, input int lv);
      en       = e;
      up_dn    = u;
      clr      = c;
      load     = l;
      load_val = 4'(lv);
      q0.push_back(model_step(0, e, u, c, l, lv));
      q1.push_back(model_step(1, e, u, c, l, lv));
      q2.push_back(model_step(2, e, u, c, l, lv));
   endtask

   task automatic step(input bit e, input bit u, input bit c, input bit l, input int lv);
      @(negedge clk);
      apply(e, u, c, l, lv);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_a_count"}, int'(if_a.count), 0);
      chk({tag, "_a_wrap"}, int'(if_a.wrap), 0);
      chk({tag, "_a_ovf"}, int'(if_a.ovf), 0);
      chk({tag, "_b_count"}, int'(if_b.count), 0);
      chk({tag, "_b_ovf"}, int'(if_b.ovf), 0);
      chk({tag, "_c_count"}, int'(if_c.count), 0);
      chk({tag, "_c_wrap"}, int'(if_c.wrap), 0);
      chk({tag, "_c_ovf"}, int'(if_c.ovf), 0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0;
         m_w[k]   = 0;
         m_o[k]   = 0;
      end
      #2;
      check_zero("async_rst");
      rst = 1'b0;
      apply(1'b1, 1'b1, 1'b0, 1'b0, 0);
   endtask

   // Monitor: one expectation per DUT is consumed after every edge that had stimulus queued
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
            e = q0.pop_front();
            chk("a_count", int'(if_a.count), e.cnt);
            chk("a_wrap", int'(if_a.wrap), e.w);
            chk("a_ovf", int'(if_a.ovf), e.o);
            chk("a_tc", int'(if_a.tc), e.t);
            e = q1.pop_front();
            chk("b_count", int'(if_b.count), e.cnt);
            chk("b_wrap", int'(if_b.wrap), e.w);
            chk("b_ovf", int'(if_b.ovf), e.o);
            chk("b_tc", int'(if_b.tc), e.t);
            e = q2.pop_front();
            chk("c_count", int'(if_c.count), e.cnt);
            chk("c_wrap", int'(if_c.wrap), e.w);
            chk("c_ovf", int'(if_c.ovf), e.o);
            chk("c_tc", int'(if_c.tc), e.t);
         end
      end
   end

   initial begin
      int r;
      repeat (2) @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Free-running up through the wrap point
      repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, 0);

      // Down from 0, then clear mid-run
      step(1'b0, 1'b1, 1'b1, 1'b0, 0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 0);

      // Long up and down runs to reach both saturation ends
      step(1'b0, 1'b1, 1'b1, 1'b0, 0);
      repeat (15) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0, 0);

      // Load, clamped load, clear over load, load over enable
      step(1'b0, 1'b1, 1'b0, 1'b1, 5);
      step(1'b0, 1'b1, 1'b0, 1'b1, 14);
      step(1'b0, 1'b1, 1'b1, 1'b1, 7);
      step(1'b1, 1'b1, 1'b0, 1'b1, 3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Asynchronous reset in the middle of a cycle
      step(1'b0, 1'b1, 1'b0, 1'b1, 6);
      async_reset();
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);

      // Randomized mix with direction changes, occasional clear and load
      repeat (400) begin
         r = $urandom_range(0, 99);
         step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              (r < 4), (r >= 4 && r < 12), $urandom_range(0, 15));
      end

      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", q0.size() + q1.size() + q2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised modulo-N up/down counter that generalises the free-running 2-bit counter. It adds programmable width and modulus, direction control, enable, synchronous clear, parallel load, and a wrap or saturate mode. Status outputs are terminal-count, a wrap pulse and a sticky overflow. It is the general counting primitive for timers, dividers and sequencers in the design.

## Interface
- `WIDTH`, default 8: counter width in bits; must be ≥ 1.
- `MAX_VAL`, default 2**WIDTH-1: highest count value. Counting range is 0..MAX_VAL. Must be ≥ 1 and < 2**WIDTH.
- `SATURATE`, default 0: 0 selects wrap mode, 1 selects saturate mode.
- `clk`, in, 1: single clock. All state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: count enable. The counter steps by one per cycle while high.
- `up_dn`, in, 1: direction. 1 counts up, 0 counts down.
- `clr`, in, 1: synchronous clear to 0.
- `load`, in, 1: synchronous parallel load.
- `load_val`, in, WIDTH: value used when `load` is high.
- `count`, out, WIDTH: registered count.
- `tc`, out, 1: terminal count, combinational.
- `wrap`, out, 1: registered one-cycle pulse.
- `ovf`, out, 1: registered sticky overflow/underflow flag.

## Operation
- **Reset.** While `rst` is high, `count`, `wrap` and `ovf` are all 0, immediately and without waiting for a clock edge.
- **Priority per edge:** `rst` > `clr` > `load` > `en`. The lower-priority controls are ignored in that cycle.
- **`clr`.** `count` becomes 0 and `ovf` becomes 0. `wrap` is 0.
- **`load`.** `count` becomes `load_val` if `load_val` ≤ MAX_VAL, otherwise it is clamped to MAX_VAL. `wrap` is 0 and `ovf` is unchanged.
- **`en` with `up_dn`=1:**
  - If `count` < MAX_VAL, `count` increments by 1.
  - At `count` = MAX_VAL in wrap mode: `count` becomes 0, and `wrap` and `ovf` are set.
  - At `count` = MAX_VAL in saturate mode: `count` holds at MAX_VAL, `ovf` is set, `wrap` stays 0.
- **`en` with `up_dn`=0:**
  - If `count` > 0, `count` decrements by 1.
  - At `count` = 0 in wrap mode: `count` becomes MAX_VAL, and `wrap` and `ovf` are set.
  - At `count` = 0 in saturate mode: `count` holds at 0, `ovf` is set.
- **Idle.** With `en` low and no `clr` or `load`, `count` holds, `wrap` is 0 and `ovf` holds.
- **`tc`.** Equals (`up_dn` AND `count` == MAX_VAL) OR (NOT `up_dn` AND `count` == 0). It is independent of `en`.
- **Arithmetic.** Compare before stepping. `count` never holds a value above MAX_VAL and no intermediate value wider than WIDTH+1 bits is used. When MAX_VAL = 2**WIDTH-1, the behaviour equals natural binary rollover.
- **Direction changes.** `up_dn` may change on any cycle. The next step uses the new direction with no penalty cycle.

## Timing
- Control-to-`count` latency is 1 cycle: inputs are sampled at edge N and the new `count` is visible after edge N.
- `wrap` is high for exactly the one cycle in which `count` shows the post-wrap value. Back-to-back wraps (MAX_VAL=1 with `en` held) give `wrap` high on consecutive cycles.
- `ovf` rises in the same cycle as the offending step and stays high until `clr` or `rst`.
- `tc` follows `count` and `up_dn` combinationally within the same cycle. It carries no register delay.
- **`rst` asserted mid-count:** outputs go to 0 asynchronously. On the first edge after deassertion the counter steps from 0 if `en` is high.
- **`clr` and `load` both high:** `clr` wins and `count` becomes 0.
- **`load` and `en` both high:** the load wins and no step is applied in that cycle.

## Structure
- Shared package `counter_pkg`:
  - `MODE_WRAP` = 0 and `MODE_SAT` = 1 constants.
  - Direction constants `DIR_UP` = 1 and `DIR_DN` = 0.
  - A function `clamp_load(val, max)` used for load clamping.
- One sub-module, `counter_step`: combinational. It takes `count`, `up_dn` and the mode, and returns `next_count`, `at_bound` and `wrapped`.
- The top level contains only the priority mux, the three registers and the `tc` decode.
- Elaboration-time checks on `WIDTH` and `MAX_VAL` legality.

## Test plan
All scenarios use `WIDTH`=4 and `MAX_VAL`=9 unless stated.

1. Wrap mode, count up: `rst` pulse, then `en`=1, `up_dn`=1 for 12 cycles → `count` goes 0,1,…,9,0,1. `wrap` is high only when `count` returns to 0. `ovf` is set from that cycle. `tc` is high while `count`=9.
2. Wrap mode, count down: `up_dn`=0 from `count`=0 → `count`=9 and `wrap` pulses. Next cycles give 8 then 7. Mid-run `clr` → `count`=0 and `ovf`=0.
3. `SATURATE`=1: count up 15 cycles → `count` holds at 9 from cycle 9 onward. `ovf` is set at the first held step and `wrap` is never high. Then `up_dn`=0 for 12 cycles → `count` holds at 0.
4. Load: `load_val`=5 → `count`=5. `load_val`=14 → `count`=9 (clamped). `load`=1 and `clr`=1 together → `count`=0. `load`=1 and `en`=1 with `load_val`=3 → `count`=3.
5. Asynchronous reset: at `count`=6, raise `rst` between clock edges → `count`, `wrap` and `ovf` are 0 before the next edge. Release `rst` with `en`=1 → `count`=1 one edge later.
6. `WIDTH`=2, `MAX_VAL`=3, free-running up → `count` sequence 0,1,2,3,0 with `wrap` every 4th cycle. This matches a plain 2-bit rollover counter.
